// File: rtl/sysid_pkg.sv
// sysid_pkg: shared constants and types for the system-ID register block.
// Address map, CTRL bit positions and default identity values.
package sysid_pkg;

  localparam logic [2:0] SYSID_ADDR_ID        = 3'd0;
  localparam logic [2:0] SYSID_ADDR_TIMESTAMP = 3'd1;
  localparam logic [2:0] SYSID_ADDR_VERSION   = 3'd2;
  localparam logic [2:0] SYSID_ADDR_SCRATCH   = 3'd3;
  localparam logic [2:0] SYSID_ADDR_UPTIME_LO = 3'd4;
  localparam logic [2:0] SYSID_ADDR_UPTIME_HI = 3'd5;
  localparam logic [2:0] SYSID_ADDR_CTRL      = 3'd6;

  localparam int CTRL_RUN = 0;
  localparam int CTRL_CLR = 1;

  localparam logic [31:0] SYS_ID_DEFAULT  = 32'h5A42_74FE;
  localparam logic [31:0] VERSION_DEFAULT = 32'h0001_0000;

  typedef struct packed {
    logic        valid;
    logic [31:0] data;
  } rd_rsp_t;

  function automatic logic [31:0] be_merge(
    input logic [31:0] old_v,
    input logic [31:0] new_v,
    input logic [3:0]  be
  );
    logic [31:0] r;
    for (int i = 0; i < 4; i++)
      r[i*8 +: 8] = be[i] ? new_v[i*8 +: 8] : old_v[i*8 +: 8];
    return r;
  endfunction

endpackage

// File: rtl/sysid_read_pipe.sv
// sysid_read_pipe: fixed-depth delay line for read responses.
// Depth 0 is a plain wire; all stages clear on reset.
module sysid_read_pipe #(
  parameter int unsigned DEPTH = 0,
  parameter int unsigned W     = 33
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  generate
    if (DEPTH == 0) begin : g_wire
      assign dout = din;
    end else begin : g_dly
      logic [W-1:0] sr [DEPTH];

      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          for (int i = 0; i < int'(DEPTH); i++)
            sr[i] <= '0;
        end else begin
          sr[0] <= din;
          for (int i = 1; i < int'(DEPTH); i++)
            sr[i] <= sr[i-1];
        end
      end

      assign dout = sr[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/sysid_info_regs.sv
// sysid_info_regs: Avalon-MM system-ID, scratch and uptime registers.
// Read mux is registered once, then delayed to READ_LATENCY.
module sysid_info_regs
  import sysid_pkg::*;
#(
  parameter logic [31:0] SYS_ID       = SYS_ID_DEFAULT,
  parameter logic [31:0] TIMESTAMP    = 32'd0,
  parameter logic [31:0] VERSION      = VERSION_DEFAULT,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [2:0]  address,
  input  logic        read,
  input  logic        write,
  input  logic [3:0]  byteenable,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        readdatavalid
);

  logic [31:0] scratch_q;
  logic        run_q;
  logic [63:0] cnt_q;
  logic [31:0] hi_snap_q;
  logic [31:0] rd_mux;
  logic [31:0] ctrl_rd;
  rd_rsp_t     rsp_d;
  rd_rsp_t     rsp_q;
  rd_rsp_t     rsp_out;

  logic wr_scratch;
  logic wr_ctrl;
  logic clr;
  logic rd_lo;

  assign wr_scratch = write && (address == SYSID_ADDR_SCRATCH);
  assign wr_ctrl    = write && (address == SYSID_ADDR_CTRL)
                    && byteenable[0];
  assign clr        = wr_ctrl && writedata[CTRL_CLR];
  assign rd_lo      = read && (address == SYSID_ADDR_UPTIME_LO);

  always_comb begin
    ctrl_rd = '0;
    ctrl_rd[CTRL_RUN] = run_q;
  end

  always_comb begin
    rd_mux = '0;
    unique case (address)
      SYSID_ADDR_ID:        rd_mux = SYS_ID;
      SYSID_ADDR_TIMESTAMP: rd_mux = TIMESTAMP;
      SYSID_ADDR_VERSION:   rd_mux = VERSION;
      SYSID_ADDR_SCRATCH:   rd_mux = scratch_q;
      SYSID_ADDR_UPTIME_LO: rd_mux = cnt_q[31:0];
      SYSID_ADDR_UPTIME_HI: rd_mux = hi_snap_q;
      SYSID_ADDR_CTRL:      rd_mux = ctrl_rd;
      default:              rd_mux = '0;
    endcase
  end

  always_comb begin
    rsp_d       = '0;
    rsp_d.valid = read;
    rsp_d.data  = read ? rd_mux : '0;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      scratch_q <= '0;
      run_q     <= 1'b1;
      cnt_q     <= '0;
      hi_snap_q <= '0;
      rsp_q     <= '0;
    end else begin
      rsp_q <= rsp_d;
      if (wr_scratch)
        scratch_q <= be_merge(scratch_q, writedata, byteenable);
      if (wr_ctrl)
        run_q <= writedata[CTRL_RUN];
      // clear wins over increment on the same edge
      if (clr)
        cnt_q <= '0;
      else if (run_q)
        cnt_q <= cnt_q + 64'd1;
      if (rd_lo)
        hi_snap_q <= cnt_q[63:32];
    end
  end

  sysid_read_pipe #(
    .DEPTH (READ_LATENCY - 1),
    .W     ($bits(rd_rsp_t))
  ) u_read_pipe (
    .clock   (clock),
    .reset_n (reset_n),
    .din     (rsp_q),
    .dout    (rsp_out)
  );

  assign readdata      = rsp_out.data;
  assign readdatavalid = rsp_out.valid;

endmodule

// File: tb/tb_sysid_info_regs.sv
// tb_sysid_info_regs: directed checks of sysid_info_regs.
// Instance uses READ_LATENCY = 3.
module tb_sysid_info_regs;

  localparam int LAT = 3;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  address = '0;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [3:0]  byteenable = '0;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic        readdatavalid;

  int total = 0;
  int bad = 0;

  sysid_info_regs #(
    .SYS_ID       (32'h5A42_74FE),
    .TIMESTAMP    (32'd0),
    .VERSION      (32'h0001_0000),
    .READ_LATENCY (LAT)
  ) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .address       (address),
    .read          (read),
    .write         (write),
    .byteenable    (byteenable),
    .writedata     (writedata),
    .readdata      (readdata),
    .readdatavalid (readdatavalid)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_read(input logic [2:0] a,
                         output logic [31:0] d,
                         output int lat);
    address = a;
    read = 1'b1;
    step();
    read = 1'b0;
    lat = 1;
    while (!readdatavalid && lat < 10) begin
      step();
      lat++;
    end
    d = readdata;
    step();
  endtask

  task automatic do_write(input logic [2:0] a,
                          input logic [31:0] d,
                          input logic [3:0] be);
    address = a;
    writedata = d;
    byteenable = be;
    write = 1'b1;
    step();
    write = 1'b0;
    byteenable = '0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    int lat;
    reset_n = 1'b0;
    step();
    step();
    total++;
    if (readdata !== 32'd0 || readdatavalid !== 1'b0) begin
      bad++;
      $display("FAIL reset_out: rd=%h rdv=%b want 0/0",
               readdata, readdatavalid);
    end
    reset_n = 1'b1;
    step();
    do_read(3'd3, d, lat);
    total++;
    if (lat != LAT) begin
      bad++;
      $display("FAIL latency: got %0d want %0d", lat, LAT);
    end
    total++;
    if (d !== 32'd0) begin
      bad++;
      $display("FAIL reset_scratch: got %h want 0", d);
    end
    do_read(3'd6, d, lat);
    total++;
    if (d !== 32'd1) begin
      bad++;
      $display("FAIL reset_ctrl: got %h want 1", d);
    end
    do_read(3'd5, d, lat);
    total++;
    if (d !== 32'd0) begin
      bad++;
      $display("FAIL reset_hi: got %h want 0", d);
    end
  endtask

  task automatic test_id_regs();
    logic [31:0] exp [3];
    exp[0] = 32'h5A42_74FE;
    exp[1] = 32'd0;
    exp[2] = 32'h0001_0000;
    address = 3'd0;
    read = 1'b1;
    step();
    address = 3'd1;
    step();
    address = 3'd2;
    step();
    read = 1'b0;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (readdatavalid !== 1'b1 || readdata !== exp[i]) begin
        bad++;
        $display("FAIL id_b2b[%0d]: rdv=%b d=%h want 1/%h",
                 i, readdatavalid, readdata, exp[i]);
      end
      step();
    end
    total++;
    if (readdatavalid !== 1'b0 || readdata !== 32'd0) begin
      bad++;
      $display("FAIL id_idle: rdv=%b d=%h want 0/0",
               readdatavalid, readdata);
    end
  endtask

  task automatic test_scratch();
    logic [31:0] d;
    int lat;
    do_write(3'd3, 32'hDEAD_BEEF, 4'b1111);
    do_write(3'd3, 32'h0000_1234, 4'b0011);
    do_read(3'd3, d, lat);
    total++;
    if (d !== 32'hDEAD_1234) begin
      bad++;
      $display("FAIL scratch_be: got %h want DEAD1234", d);
    end
    do_write(3'd3, 32'h1100_0000, 4'b1000);
    do_read(3'd3, d, lat);
    total++;
    if (d !== 32'h11AD_1234) begin
      bad++;
      $display("FAIL scratch_b3: got %h want 11AD1234", d);
    end
  endtask

  task automatic test_rw_same();
    logic [31:0] d;
    int lat;
    address = 3'd3;
    writedata = 32'hCAFE_F00D;
    byteenable = 4'b1111;
    write = 1'b1;
    read = 1'b1;
    step();
    write = 1'b0;
    read = 1'b0;
    step();
    step();
    total++;
    if (readdatavalid !== 1'b1 || readdata !== 32'h11AD_1234) begin
      bad++;
      $display("FAIL rw_same_old: rdv=%b d=%h want 1/11AD1234",
               readdatavalid, readdata);
    end
    step();
    do_read(3'd3, d, lat);
    total++;
    if (d !== 32'hCAFE_F00D) begin
      bad++;
      $display("FAIL rw_same_new: got %h want CAFEF00D", d);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a;
    logic [31:0] b;
    address = 3'd4;
    read = 1'b1;
    step();
    step();
    read = 1'b0;
    step();
    a = readdata;
    step();
    b = readdata;
    total++;
    if (b - a !== 32'd1) begin
      bad++;
      $display("FAIL lo_b2b: got %h then %h want +1", a, b);
    end
    step();
  endtask

  task automatic test_uptime_carry();
    logic [31:0] d;
    int lat;
    force dut.cnt_q = 64'h0000_0005_FFFF_FFFE;
    do_read(3'd4, d, lat);
    release dut.cnt_q;
    total++;
    if (d !== 32'hFFFF_FFFE) begin
      bad++;
      $display("FAIL carry_lo: got %h want FFFFFFFE", d);
    end
    repeat (10) step();
    do_read(3'd5, d, lat);
    total++;
    if (d !== 32'h0000_0005) begin
      bad++;
      $display("FAIL carry_hi: got %h want 00000005", d);
    end
  endtask

  task automatic test_ctrl();
    logic [31:0] a;
    logic [31:0] b;
    int lat;
    do_write(3'd6, 32'd0, 4'b0001);
    repeat (20) step();
    do_read(3'd4, a, lat);
    do_read(3'd4, b, lat);
    total++;
    if (a !== b) begin
      bad++;
      $display("FAIL stopped: got %h then %h want equal", a, b);
    end
    do_write(3'd6, 32'd3, 4'b0001);
    do_read(3'd4, a, lat);
    total++;
    if (a > 32'(3 + LAT)) begin
      bad++;
      $display("FAIL clr_lo: got %h want <= %0d", a, 3 + LAT);
    end
    do_read(3'd6, b, lat);
    total++;
    if (b !== 32'd1) begin
      bad++;
      $display("FAIL ctrl_rd: got %h want 1", b);
    end
  endtask

  task automatic test_ro_writes();
    logic [31:0] d;
    int lat;
    do_write(3'd0, 32'h1234_5678, 4'b1111);
    do_write(3'd7, 32'hFFFF_FFFF, 4'b1111);
    do_write(3'd2, 32'hFFFF_FFFF, 4'b1111);
    do_read(3'd0, d, lat);
    total++;
    if (d !== 32'h5A42_74FE) begin
      bad++;
      $display("FAIL ro_id: got %h want 5A4274FE", d);
    end
    do_read(3'd7, d, lat);
    total++;
    if (d !== 32'd0) begin
      bad++;
      $display("FAIL ro_a7: got %h want 0", d);
    end
    do_read(3'd2, d, lat);
    total++;
    if (d !== 32'h0001_0000) begin
      bad++;
      $display("FAIL ro_ver: got %h want 00010000", d);
    end
  endtask

  task automatic test_reset_inflight();
    logic [31:0] d;
    int lat;
    int seen;
    address = 3'd0;
    read = 1'b1;
    step();
    step();
    read = 1'b0;
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (readdatavalid)
        seen++;
      step();
    end
    total++;
    if (seen != 0) begin
      bad++;
      $display("FAIL inflight: got %0d responses want 0", seen);
    end
    do_read(3'd3, d, lat);
    total++;
    if (d !== 32'd0) begin
      bad++;
      $display("FAIL rst_scratch: got %h want 0", d);
    end
  endtask

  initial begin
    test_reset();
    test_id_regs();
    test_scratch();
    test_rw_same();
    test_back_to_back();
    test_uptime_carry();
    test_ctrl();
    test_ro_writes();
    test_reset_inflight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
